// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage core: register file geometry,
// opcode constants, the NOP encoding and the scheduler state type.
package cpu_pkg;

  localparam int unsigned NREGS   = 16;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned INSTR_W = 16;

  // All-zero word decodes to an instruction with every control bit clear
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sched_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register countdown of in-flight writes; nonzero means the register-file
// value is not yet visible to a decode-stage read.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned WB_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [REG_W-1:0] wr_idx_i,
  input  logic [REG_W-1:0] rs1_idx_i,
  input  logic [REG_W-1:0] rs2_idx_i,
  input  logic [REG_W-1:0] rd_idx_i,
  output logic             rs1_busy_c_o,
  output logic             rs2_busy_c_o,
  output logic             rd_busy_c_o
);

  localparam int unsigned     SB_W    = $clog2(WB_LATENCY + 1);
  localparam logic [SB_W-1:0] SB_LOAD = SB_W'(WB_LATENCY);

  logic [SB_W-1:0] sb_q [NUM_REGS];
  logic [SB_W-1:0] sb_d [NUM_REGS];

  // Issue load overrides the per-cycle decrement for the written entry
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      sb_d[i] = sb_q[i];
      if (wr_en_i && (wr_idx_i == REG_W'(i))) begin
        sb_d[i] = SB_LOAD;
      end else if (sb_q[i] != '0) begin
        sb_d[i] = sb_q[i] - SB_W'(1);
      end
    end
  end

  // Counter array register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        sb_q[i] <= sb_d[i];
      end
    end
  end

  // Lookups see pre-update values so a read of its own destination checks the older producer
  assign rs1_busy_c_o = (sb_q[rs1_idx_i] != '0);
  assign rs2_busy_c_o = (sb_q[rs2_idx_i] != '0);
  assign rd_busy_c_o  = (sb_q[rd_idx_i]  != '0);

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage pipeline control: RAW stall against the write scoreboard,
// wrong-path flush after a redirect, and saturating stall/flush statistics.
module hazard_scheduler #(
  parameter int unsigned NREGS        = 16,
  parameter int unsigned WB_LATENCY   = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic [cpu_pkg::REG_W-1:0] dec_rs1,
  input  logic [cpu_pkg::REG_W-1:0] dec_rs2,
  input  logic [cpu_pkg::REG_W-1:0] dec_rd,
  input  logic                      dec_use_rs1,
  input  logic                      dec_use_rs2,
  input  logic                      dec_use_rd_src,
  input  logic                      dec_wre,
  input  logic                      ex_redirect,
  input  logic                      clr_stats,
  output logic                      pc_en,
  output logic                      fd_en,
  output logic                      fd_flush,
  output logic                      de_bubble,
  output logic                      issue,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  import cpu_pkg::*;

  localparam int unsigned      FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'((FLUSH_CYCLES > 0) ? (FLUSH_CYCLES - 1) : 0);
  // With a single bubble cycle the redirect cycle alone covers it
  localparam sched_state_t     REDIR_STATE = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  sched_state_t     state_q, state_d;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             rs1_busy, rs2_busy, rd_busy;
  logic             raw_c;
  logic             stall_inc, flush_inc;

  reg_scoreboard #(
    .NUM_REGS   (NREGS),
    .WB_LATENCY (WB_LATENCY)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (issue & dec_wre),
    .wr_idx_i     (dec_rd),
    .rs1_idx_i    (dec_rs1),
    .rs2_idx_i    (dec_rs2),
    .rd_idx_i     (dec_rd),
    .rs1_busy_c_o (rs1_busy),
    .rs2_busy_c_o (rs2_busy),
    .rd_busy_c_o  (rd_busy)
  );

  assign raw_c = dec_valid & ((dec_use_rs1 & rs1_busy) |
                              (dec_use_rs2 & rs2_busy) |
                              (dec_use_rd_src & rd_busy));

  // State and flush-counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state: redirect enters/re-arms FLUSH; FLUSH drains its counter back to RUN
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (ex_redirect) begin
          state_d = REDIR_STATE;
          fcnt_d  = FC_LOAD;
        end
      end
      FLUSH: begin
        if (ex_redirect) begin
          fcnt_d = FC_LOAD;
        end else if (fcnt_q <= FC_W'(1)) begin
          state_d = RUN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = '0;
      end
    endcase
  end

  // Pipeline enables; reset forces the free-running defaults regardless of inputs
  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    fd_flush  = 1'b0;
    de_bubble = 1'b0;
    issue     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst) begin
      case (state_q)
        RUN: begin
          if (ex_redirect) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            flush_inc = 1'b1;
          end else if (raw_c) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_bubble = 1'b1;
            stall_inc = 1'b1;
          end else begin
            issue = dec_valid;
          end
        end
        FLUSH: begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
          flush_inc = 1'b1;
        end
        default: begin
          de_bubble = 1'b1;
        end
      endcase
    end
  end

  // Saturating statistics; clear beats increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Statistics register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
